// File: rtl/uart_to_bus_fifo.sv
// uart_to_bus_fifo: bit-per-clock serial receiver feeding a FIFO that is drained onto a
// bit-serial address+data bus. Every received word is answered with a serial ACK (or NACK
// when the FIFO is full and the word is dropped).
//
// Ports:
//   clk            bus clock, rising edge
//   reset          asynchronous, active-low
//   data_rx        serial in, idle high, 0 = start bit, then DATA_W bits MSB first
//   bus_ready      bus grant/ready from the slave side
//   ack_out        serial ACK/NACK: one 0 start bit then 8 pattern bits MSB first, idle high
//   bus_req        bus request, high from request until the last bit is sent
//   addr_tx        serial address bit, MSB first
//   data_tx        serial data bit, MSB first
//   valid          request-valid while waiting for the first grant of a frame
//   valid_s        frame-valid while a bit is presented
//   write_en_slave constant 1 once out of reset
//   data_read      last word popped for transfer
//   fifo_count     FIFO occupancy
//   overflow       one-cycle pulse when a received word is dropped
//
// Build option: define ADDR_AUTOINC_EN to advance the target address by one after every
// completed transfer; otherwise every transfer goes to ADDR_BASE.
module uart_to_bus_fifo #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 14,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] ADDR_BASE  = 14'b01000000000000,
  parameter int unsigned       TIMEOUT    = 64,
  parameter logic [7:0]        ACK_PAT    = 8'b11001100,
  parameter logic [7:0]        NACK_PAT   = 8'b11110000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_rx,
  input  logic                          bus_ready,
  output logic                          ack_out,
  output logic                          bus_req,
  output logic                          addr_tx,
  output logic                          data_tx,
  output logic                          valid,
  output logic                          valid_s,
  output logic                          write_en_slave,
  output logic [DATA_W-1:0]             data_read,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned XferLen = ADDR_W + DATA_W;
  localparam int unsigned BitCntW = $clog2(XferLen + 1);
  localparam int unsigned RxCntW  = $clog2(DATA_W + 1);
  localparam int unsigned WaitW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RIdle, RData, RPush} rx_state_e;
  typedef enum logic [1:0] {AIdle, AStart, ABits} ack_state_e;
  typedef enum logic [2:0] {MIdle, MReq, MXfer, MHold, MDone} m_state_e;

  rx_state_e             rx_state_q;
  logic [RxCntW-1:0]     rx_cnt_q;
  logic [DATA_W-1:0]     rx_sh_q;

  ack_state_e            ack_state_q;
  logic [7:0]            ack_sh_q;
  logic [2:0]            ack_cnt_q;

  m_state_e              m_state_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic [WaitW-1:0]      wait_cnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W-1:0]     addr_sh_q;
  logic [DATA_W-1:0]     data_sh_q;

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_W-1:0]     fifo_head;

  assign fifo_full  = (fifo_count == CntW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = (rx_state_q == RPush) && !fifo_full;
  assign pop        = (m_state_q == MDone);
  assign fifo_head  = mem_q[rd_ptr_q];

  // Receiver: start bit, DATA_W data bits MSB first, then one push/drop cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RIdle;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      unique case (rx_state_q)
        RIdle: begin
          if (!data_rx) begin
            rx_state_q <= RData;
            rx_cnt_q   <= '0;
          end
        end
        RData: begin
          rx_sh_q <= {rx_sh_q[DATA_W-2:0], data_rx};
          if (rx_cnt_q == RxCntW'(DATA_W - 1)) begin
            rx_state_q <= RPush;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RPush: begin
          overflow   <= fifo_full;
          rx_state_q <= RIdle;
        end
        default: rx_state_q <= RIdle;
      endcase
    end
  end

  // FIFO storage has no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_sh_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ACK/NACK sender. A frame takes at least 10 cycles and a reply 9, so replies never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_state_q <= AIdle;
      ack_out     <= 1'b1;
      ack_sh_q    <= '0;
      ack_cnt_q   <= '0;
    end else begin
      unique case (ack_state_q)
        AIdle: begin
          if (rx_state_q == RPush) begin
            ack_state_q <= AStart;
            ack_out     <= 1'b0;
            ack_sh_q    <= fifo_full ? NACK_PAT : ACK_PAT;
          end
        end
        AStart: begin
          ack_state_q <= ABits;
          ack_out     <= ack_sh_q[7];
          ack_sh_q    <= {ack_sh_q[6:0], 1'b0};
          ack_cnt_q   <= '0;
        end
        ABits: begin
          if (ack_cnt_q == 3'd7) begin
            ack_state_q <= AIdle;
            ack_out     <= 1'b1;
          end else begin
            ack_out   <= ack_sh_q[7];
            ack_sh_q  <= {ack_sh_q[6:0], 1'b0};
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        default: begin
          ack_state_q <= AIdle;
          ack_out     <= 1'b1;
        end
      endcase
    end
  end

  // Bus master. bit_cnt_q is the index of the bit currently on addr_tx/data_tx; a bit is
  // consumed on an edge where bus_ready is high, otherwise it is presented again after the hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state_q      <= MIdle;
      bit_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      addr_q         <= ADDR_BASE;
      addr_sh_q      <= '0;
      data_sh_q      <= '0;
      bus_req        <= 1'b0;
      valid          <= 1'b0;
      valid_s        <= 1'b0;
      addr_tx        <= 1'b0;
      data_tx        <= 1'b0;
      data_read      <= '0;
      write_en_slave <= 1'b0;
    end else begin
      write_en_slave <= 1'b1;
      unique case (m_state_q)
        MIdle: begin
          if (!fifo_empty) begin
            m_state_q <= MReq;
            bus_req   <= 1'b1;
            valid     <= 1'b1;
            bit_cnt_q <= '0;
            addr_sh_q <= addr_q;
            data_sh_q <= fifo_head;
          end
        end
        MReq: begin
          if (bus_ready) begin
            m_state_q <= MXfer;
            valid     <= 1'b0;
            valid_s   <= 1'b1;
            bit_cnt_q <= '0;
            addr_tx   <= addr_sh_q[ADDR_W-1];
            addr_sh_q <= {addr_sh_q[ADDR_W-2:0], 1'b0};
            data_tx   <= 1'b0;
          end
        end
        MXfer: begin
          if (!bus_ready) begin
            m_state_q  <= MHold;
            valid_s    <= 1'b0;
            wait_cnt_q <= '0;
          end else if (bit_cnt_q == BitCntW'(XferLen - 1)) begin
            m_state_q <= MDone;
            valid_s   <= 1'b0;
            bus_req   <= 1'b0;
            addr_tx   <= 1'b0;
            data_tx   <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q < BitCntW'(ADDR_W - 1)) begin
              addr_tx   <= addr_sh_q[ADDR_W-1];
              addr_sh_q <= {addr_sh_q[ADDR_W-2:0], 1'b0};
              data_tx   <= 1'b0;
            end else begin
              addr_tx   <= 1'b0;
              data_tx   <= data_sh_q[DATA_W-1];
              data_sh_q <= {data_sh_q[DATA_W-2:0], 1'b0};
            end
          end
        end
        MHold: begin
          if (bus_ready) begin
            m_state_q  <= MXfer;
            valid_s    <= 1'b1;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
            // Abort: re-request and resend the whole frame; the word stays at the FIFO head.
            m_state_q  <= MReq;
            valid      <= 1'b1;
            bit_cnt_q  <= '0;
            addr_sh_q  <= addr_q;
            data_sh_q  <= fifo_head;
            addr_tx    <= 1'b0;
            data_tx    <= 1'b0;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        MDone: begin
          m_state_q <= MIdle;
          data_read <= fifo_head;
`ifdef ADDR_AUTOINC_EN
          addr_q    <= addr_q + 1'b1;
`else
          addr_q    <= ADDR_BASE;
`endif
        end
        default: m_state_q <= MIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_to_bus_fifo.sv
module tb_uart_to_bus_fifo;

  localparam int unsigned       DATA_W     = 8;
  localparam int unsigned       ADDR_W     = 14;
  localparam int unsigned       FIFO_DEPTH = 4;
  localparam int unsigned       TIMEOUT    = 64;
  localparam logic [ADDR_W-1:0] ADDR_BASE  = 14'h1000;
  localparam logic [7:0]        ACK_PAT    = 8'b11001100;
  localparam logic [7:0]        NACK_PAT   = 8'b11110000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data_rx = 1'b1;
  logic bus_ready = 1'b0;
  logic ack_out, bus_req, addr_tx, data_tx, valid, valid_s, write_en_slave, overflow;
  logic [DATA_W-1:0] data_read;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Bus-side observation, assembled from the wire protocol only.
  int                mon_idx = 0;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_data;
  logic [ADDR_W-1:0] xfer_addr_q[$];
  logic [DATA_W-1:0] xfer_data_q[$];
  int                ack_cnt = 0;
  logic [7:0]        ack_sh;
  logic [7:0]        ack_q[$];
  int                ovf_cnt = 0;
  int                req_rises = 0;
  int                vs_low_cnt = 0;
  int                vs_high_cnt = 0;
  int                proto_err = 0;
  bit                saw_req = 0;
  logic              valid_prev = 1'b0;
  logic [ADDR_W-1:0] exp_addr = ADDR_BASE;

  uart_to_bus_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .data_rx        (data_rx),
    .bus_ready      (bus_ready),
    .ack_out        (ack_out),
    .bus_req        (bus_req),
    .addr_tx        (addr_tx),
    .data_tx        (data_tx),
    .valid          (valid),
    .valid_s        (valid_s),
    .write_en_slave (write_en_slave),
    .data_read      (data_read),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Sample on the falling edge: these are the values the next rising edge will act on.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mon_idx    = 0;
      ack_cnt    = 0;
      valid_prev = 1'b0;
    end else begin
      if (valid && !valid_prev) req_rises++;
      valid_prev = valid;
      if (valid) mon_idx = 0;
      if (bus_req) saw_req = 1;
      if (overflow) ovf_cnt++;
      if (valid_s) vs_high_cnt++;
      if (bus_req && !valid && !valid_s) vs_low_cnt++;
      if (valid_s && bus_ready) begin
        if (mon_idx < ADDR_W) begin
          mon_addr[ADDR_W-1-mon_idx] = addr_tx;
          if (data_tx !== 1'b0) proto_err++;
        end else begin
          mon_data[DATA_W-1-(mon_idx-ADDR_W)] = data_tx;
          if (addr_tx !== 1'b0) proto_err++;
        end
        mon_idx++;
        if (mon_idx == ADDR_W + DATA_W) begin
          xfer_addr_q.push_back(mon_addr);
          xfer_data_q.push_back(mon_data);
          mon_idx = 0;
        end
      end
      if (ack_cnt == 0) begin
        if (ack_out == 1'b0) ack_cnt = 1;
      end else begin
        ack_sh = {ack_sh[6:0], ack_out};
        ack_cnt++;
        if (ack_cnt == 9) begin
          ack_q.push_back(ack_sh);
          ack_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w);
    data_rx = 1'b0;
    tick();
    for (int i = 0; i < DATA_W; i++) begin
      data_rx = w[DATA_W-1-i];
      tick();
    end
    data_rx = 1'b1;
    tick();
  endtask

  task automatic wait_xfers(input int n, input int budget);
    for (int c = 0; c < budget && xfer_data_q.size() < n; c++) tick();
  endtask

  task automatic bump_addr();
`ifdef ADDR_AUTOINC_EN
    exp_addr = exp_addr + 1'b1;
`endif
  endtask

  task automatic clear_mon();
    xfer_addr_q.delete();
    xfer_data_q.delete();
    ack_q.delete();
    ovf_cnt = 0;
    req_rises = 0;
    vs_low_cnt = 0;
    vs_high_cnt = 0;
    proto_err = 0;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    reset = 1'b0;
    repeat (3) tick();
    flags = {ack_out, bus_req, valid, valid_s, addr_tx, data_tx, write_en_slave, overflow};
    checks++;
    if (flags !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want %b", flags, 8'b1000_0000);
    end
    checks++;
    if (fifo_count !== '0 || data_read !== '0) begin
      errors++;
      $display("FAIL reset_count_data: got count %0d data %h want 0 0", fifo_count, data_read);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (write_en_slave !== 1'b1) begin
      errors++;
      $display("FAIL write_en_after_reset: got %b want 1", write_en_slave);
    end
  endtask

  task automatic test_single();
    clear_mon();
    bus_ready = 1'b1;
    send_frame(8'hA5);
    wait_xfers(1, 100);
    repeat (4) tick();
    checks++;
    if (ack_q.size() != 1 || ack_q[0] !== ACK_PAT) begin
      errors++;
      $display("FAIL single_ack: got %0d replies first %b want 1 reply %b", ack_q.size(), ack_q[0],
               ACK_PAT);
    end
    checks++;
    if (xfer_data_q.size() != 1 || xfer_addr_q[0] !== exp_addr || xfer_data_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_xfer: got %0d frames addr %h data %h want 1 frame addr %h data a5",
               xfer_data_q.size(), xfer_addr_q[0], xfer_data_q[0], exp_addr);
    end
    bump_addr();
    checks++;
    if (vs_high_cnt != ADDR_W + DATA_W) begin
      errors++;
      $display("FAIL single_valid_s_len: got %0d want %0d", vs_high_cnt, ADDR_W + DATA_W);
    end
    checks++;
    if (data_read !== 8'hA5 || fifo_count !== '0) begin
      errors++;
      $display("FAIL single_done: got data_read %h count %0d want a5 0", data_read, fifo_count);
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL single_idle_lanes: got %0d nonzero idle-lane bits want 0", proto_err);
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(DATA_W'(8'h11 + i));
    repeat (12) tick();
    checks++;
    if (fifo_count !== 3'(FIFO_DEPTH)) begin
      errors++;
      $display("FAIL ovf_count: got %0d want %0d", fifo_count, FIFO_DEPTH);
    end
    checks++;
    if (ovf_cnt != 1) begin
      errors++;
      $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt);
    end
    checks++;
    if (ack_q.size() != 5) begin
      errors++;
      $display("FAIL ovf_reply_count: got %0d want 5", ack_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ack_q[i] !== ((i < FIFO_DEPTH) ? ACK_PAT : NACK_PAT)) begin
          errors++;
          $display("FAIL ovf_reply_%0d: got %b want %b", i, ack_q[i],
                   (i < FIFO_DEPTH) ? ACK_PAT : NACK_PAT);
        end
      end
    end
    bus_ready = 1'b1;
    wait_xfers(4, 200);
    repeat (40) tick();
    checks++;
    if (xfer_data_q.size() != FIFO_DEPTH) begin
      errors++;
      $display("FAIL ovf_drain_count: got %0d want %0d", xfer_data_q.size(), FIFO_DEPTH);
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        checks++;
        if (xfer_data_q[i] !== DATA_W'(8'h11 + i) || xfer_addr_q[i] !== exp_addr) begin
          errors++;
          $display("FAIL ovf_drain_%0d: got addr %h data %h want addr %h data %h", i,
                   xfer_addr_q[i], xfer_data_q[i], exp_addr, 8'h11 + i);
        end
        bump_addr();
      end
    end
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL ovf_empty: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_hold_resume();
    clear_mon();
    bus_ready = 1'b1;
    send_frame(8'h3C);
    for (int n = 0; n < 60 && mon_idx != 5; n++) tick();
    bus_ready = 1'b0;
    repeat (3) tick();
    bus_ready = 1'b1;
    wait_xfers(1, 100);
    repeat (4) tick();
    checks++;
    if (vs_low_cnt != 3) begin
      errors++;
      $display("FAIL hold_len: got %0d want 3", vs_low_cnt);
    end
    checks++;
    if (xfer_data_q.size() != 1 || xfer_data_q[0] !== 8'h3C || xfer_addr_q[0] !== exp_addr) begin
      errors++;
      $display("FAIL hold_xfer: got %0d frames addr %h data %h want 1 frame addr %h data 3c",
               xfer_data_q.size(), xfer_addr_q[0], xfer_data_q[0], exp_addr);
    end
    bump_addr();
    checks++;
    if (req_rises != 1 || proto_err != 0) begin
      errors++;
      $display("FAIL hold_no_retry: got %0d requests %0d lane errors want 1 0", req_rises,
               proto_err);
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    bus_ready = 1'b1;
    send_frame(8'h96);
    for (int n = 0; n < 80 && mon_idx != ADDR_W + 3; n++) tick();
    bus_ready = 1'b0;
    repeat (80) tick();
    bus_ready = 1'b1;
    wait_xfers(1, 100);
    repeat (4) tick();
    checks++;
    if (req_rises != 2) begin
      errors++;
      $display("FAIL timeout_retry: got %0d requests want 2", req_rises);
    end
    checks++;
    if (vs_low_cnt != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_hold_len: got %0d want %0d", vs_low_cnt, TIMEOUT);
    end
    checks++;
    if (xfer_data_q.size() != 1 || xfer_data_q[0] !== 8'h96 || xfer_addr_q[0] !== exp_addr) begin
      errors++;
      $display("FAIL timeout_xfer: got %0d frames addr %h data %h want 1 frame addr %h data 96",
               xfer_data_q.size(), xfer_addr_q[0], xfer_data_q[0], exp_addr);
    end
    bump_addr();
  endtask

  task automatic test_addr();
    logic [ADDR_W-1:0] first_addr;
    clear_mon();
    bus_ready = 1'b0;
    send_frame(8'h5A);
    send_frame(8'hC3);
    bus_ready = 1'b1;
    wait_xfers(2, 120);
    repeat (4) tick();
    first_addr = exp_addr;
    checks++;
    if (xfer_addr_q.size() != 2 || xfer_addr_q[0] !== first_addr) begin
      errors++;
      $display("FAIL addr_first: got %0d frames addr %h want 2 frames addr %h",
               xfer_addr_q.size(), xfer_addr_q[0], first_addr);
    end
    bump_addr();
    checks++;
    if (xfer_addr_q[1] !== exp_addr || xfer_data_q[1] !== 8'hC3) begin
      errors++;
      $display("FAIL addr_second: got addr %h data %h want addr %h data c3", xfer_addr_q[1],
               xfer_data_q[1], exp_addr);
    end
    bump_addr();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] words[$];
    int k;
    int acc;
    for (int it = 0; it < 4; it++) begin
      clear_mon();
      words.delete();
      k = $urandom_range(1, 6);
      acc = (k < FIFO_DEPTH) ? k : FIFO_DEPTH;
      bus_ready = 1'b0;
      for (int i = 0; i < k; i++) begin
        words.push_back(DATA_W'($urandom));
        send_frame(words[i]);
      end
      repeat (12) tick();
      checks++;
      if (fifo_count !== 3'(acc) || ovf_cnt != k - acc || ack_q.size() != k) begin
        errors++;
        $display("FAIL rand%0d_fill: got count %0d drops %0d replies %0d want %0d %0d %0d", it,
                 fifo_count, ovf_cnt, ack_q.size(), acc, k - acc, k);
      end
      for (int c = 0; c < 3000 && xfer_data_q.size() < acc; c++) begin
        bus_ready = ($urandom_range(0, 7) != 0);
        tick();
      end
      bus_ready = 1'b1;
      repeat (5) tick();
      checks++;
      if (xfer_data_q.size() != acc) begin
        errors++;
        $display("FAIL rand%0d_frames: got %0d want %0d", it, xfer_data_q.size(), acc);
      end else begin
        for (int i = 0; i < acc; i++) begin
          checks++;
          if (xfer_data_q[i] !== words[i] || xfer_addr_q[i] !== exp_addr) begin
            errors++;
            $display("FAIL rand%0d_xfer%0d: got addr %h data %h want addr %h data %h", it, i,
                     xfer_addr_q[i], xfer_data_q[i], exp_addr, words[i]);
          end
          bump_addr();
        end
      end
      checks++;
      if (data_read !== words[acc-1] || fifo_count !== '0 || proto_err != 0) begin
        errors++;
        $display("FAIL rand%0d_end: got data_read %h count %0d lane errors %0d want %h 0 0", it,
                 data_read, fifo_count, proto_err, words[acc-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] flags;
    clear_mon();
    bus_ready = 1'b0;
    send_frame(8'h31);
    send_frame(8'h32);
    send_frame(8'h33);
    bus_ready = 1'b1;
    for (int n = 0; n < 60 && mon_idx != 6; n++) tick();
    reset = 1'b0;
    #1;
    flags = {ack_out, bus_req, valid, valid_s, addr_tx, data_tx, write_en_slave, overflow};
    checks++;
    if (flags !== 8'b1000_0000 || fifo_count !== '0 || data_read !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got flags %b count %0d data %h want 10000000 0 00", flags,
               fifo_count, data_read);
    end
    repeat (3) tick();
    clear_mon();
    exp_addr = ADDR_BASE;
    reset = 1'b1;
    saw_req = 0;
    repeat (40) tick();
    checks++;
    if (saw_req || fifo_count !== '0 || xfer_data_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_after: got req %0d count %0d frames %0d want 0 0 0", saw_req,
               fifo_count, xfer_data_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_hold_resume();
    test_timeout();
    test_addr();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
